// File: rtl/i2c_reg_bank_if.sv
`default_nettype none
// ============================================================================
// Module   : i2c_reg_bank_if
// Brief    : Byte-stream link between the I2C byte slave and the register bank.
// Revision : 1.0
// ============================================================================
interface i2c_reg_bank_if;
    logic       txn_start_stb;
    logic [7:0] rx_data;
    logic       rx_valid_stb;
    logic       tx_done_stb;
    logic [7:0] tx_data;

    modport master (
        output txn_start_stb,
        output rx_data,
        output rx_valid_stb,
        output tx_done_stb,
        input  tx_data
    );

    modport slave (
        input  txn_start_stb,
        input  rx_data,
        input  rx_valid_stb,
        input  tx_done_stb,
        output tx_data
    );
endinterface
`default_nettype wire

// File: rtl/i2c_reg_bank.sv
`default_nettype none
// ============================================================================
// Module   : i2c_reg_bank
// Brief    : Pointer-addressed 8-bit register file behind a byte-level I2C slave.
// Revision : 1.0
// ============================================================================
module i2c_reg_bank #(
    parameter int                    NUM_REGS   = 8,
    parameter int                    PTR_W      = 7,
    parameter logic [NUM_REGS-1:0]   RO_MASK    = '0,
    parameter logic [NUM_REGS*8-1:0] RESET_VALS = '0,
    parameter int                    AUTO_INC   = 1,
    parameter int                    WRAP       = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    i2c_reg_bank_if.slave         bus,
    input  logic [NUM_REGS*8-1:0] status_in,
    output logic [NUM_REGS*8-1:0] regs_q,
    output logic [NUM_REGS-1:0]   wr_stb,
    output logic [7:0]            ptr_q,
    output logic                  err_stb
);

    localparam logic [7:0] c_NUM_REGS = 8'(NUM_REGS);
    localparam logic [7:0] c_LAST_PTR = 8'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_PTR = 2'd1,
        ST_DATA     = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [7:0]              r_ptr;
    logic [7:0]              w_ptr_nxt;
    logic [7:0]              w_ptr_adv;
    logic [NUM_REGS*8-1:0]   r_regs;
    logic [NUM_REGS-1:0]     r_wr_stb;
    logic [NUM_REGS-1:0]     w_wr_nxt;
    logic [NUM_REGS-1:0]     w_hit;
    logic                    r_err_stb;
    logic                    w_err_nxt;
    logic [7:0]              r_tx_data;
    logic [7:0]              w_tx_nxt;
    logic                    r_tx_live0;
    logic                    w_in_range;
    logic [PTR_W-1:0]        w_ptr_idx;

    // Range check uses the whole pointer byte; slot decode only needs PTR_W bits.
    assign w_in_range = (r_ptr < c_NUM_REGS);
    assign w_ptr_idx  = r_ptr[PTR_W-1:0];

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_slot
        assign w_hit[i]          = w_in_range && (w_ptr_idx == PTR_W'(i));
        assign regs_q[8*i +: 8]  = RO_MASK[i] ? status_in[8*i +: 8] : r_regs[8*i +: 8];
    end

    always_comb begin
        w_ptr_adv = r_ptr;
        if (AUTO_INC != 0) begin
            if (r_ptr == c_LAST_PTR) begin
                w_ptr_adv = (WRAP != 0) ? 8'd0 : r_ptr;
            end else if (w_in_range) begin
                w_ptr_adv = r_ptr + 8'd1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_wr_nxt    = '0;
        w_err_nxt   = 1'b0;
        if (bus.txn_start_stb) begin
            w_state_nxt = ST_WAIT_PTR;
        end else begin
            case (r_state)
                ST_WAIT_PTR: begin
                    if (bus.rx_valid_stb) begin
                        w_ptr_nxt   = bus.rx_data;
                        w_state_nxt = ST_DATA;
                    end else if (bus.tx_done_stb) begin
                        w_ptr_nxt = w_ptr_adv;
                        w_err_nxt = !w_in_range;
                    end
                end
                ST_DATA: begin
                    if (bus.rx_valid_stb || bus.tx_done_stb) begin
                        w_ptr_nxt = w_ptr_adv;
                        w_err_nxt = !w_in_range;
                        if (bus.rx_valid_stb) begin
                            w_wr_nxt = w_hit & ~RO_MASK;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_tx_nxt = 8'hFF;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_hit[i]) begin
                w_tx_nxt = regs_q[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr      <= 8'd0;
            r_regs     <= RESET_VALS;
            r_wr_stb   <= '0;
            r_err_stb  <= 1'b0;
            r_tx_data  <= RESET_VALS[7:0];
            r_tx_live0 <= RO_MASK[0];
        end else begin
            r_ptr      <= w_ptr_nxt;
            r_wr_stb   <= w_wr_nxt;
            r_err_stb  <= w_err_nxt;
            r_tx_data  <= w_tx_nxt;
            r_tx_live0 <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_wr_nxt[i]) begin
                    r_regs[8*i +: 8] <= bus.rx_data;
                end
            end
        end
    end

    // Until the first clock after reset, a read-only slot 0 is shown live.
    assign bus.tx_data = r_tx_live0 ? status_in[7:0] : r_tx_data;
    assign wr_stb      = r_wr_stb;
    assign err_stb     = r_err_stb;
    assign ptr_q       = r_ptr;

endmodule
`default_nettype wire

// File: doc/i2c_reg_bank.md
Name: i2c_reg_bank

Overview:
- Parametrised register file that sits behind the byte-level I2C slave (i2c_simple_slave) and turns its raw byte stream into addressed register accesses.
- The first byte written after a START is the register pointer. Further written bytes go to the pointed register, with optional pointer auto-increment. Master reads return the pointed register, then advance the pointer.
- Any register can be read-only; a read-only register reads a live status input. This replaces ad-hoc per-design byte decoding, such as driving LEDs from rx bits.

Parameters:
- NUM_REGS, 8, number of 8-bit registers (1..128).
- PTR_W, 7, pointer width; the full pointer byte is compared against NUM_REGS.
- RO_MASK, 0, NUM_REGS-bit mask; bit i=1 makes reg i read-only, sourced from status_in.
- RESET_VALS, 0, NUM_REGS*8-bit flat reset image; reg i = bits [8i+7:8i].
- AUTO_INC, 1, 1 = pointer increments after each data byte written or read; 0 = pointer holds.
- WRAP, 1, 1 = pointer wraps NUM_REGS-1 -> 0; 0 = pointer saturates at NUM_REGS-1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- txn_start_stb  in  1  one-cycle pulse on START or repeated START addressed to this slave.
- rx_data  in  8  byte received from master.
- rx_valid_stb  in  1  one-cycle pulse; rx_data valid.
- tx_done_stb  in  1  one-cycle pulse; master has clocked out the current tx_data byte.
- tx_data  out  8  byte presented to slave for the next master read.
- status_in  in  NUM_REGS*8  live values for read-only registers; ignored where RO_MASK=0.
- regs_q  out  NUM_REGS*8  current contents of all registers; read-only slots show status_in.
- wr_stb  out  NUM_REGS  one-cycle pulse on bit i when reg i is written.
- ptr_q  out  8  current pointer.
- err_stb  out  1  one-cycle pulse on an access with an out-of-range pointer.

Behaviour:
- Reset (async, rst=1):
  - regs = RESET_VALS; ptr=0; state=IDLE.
  - wr_stb=0, err_stb=0, tx_data = value of reg 0 (RESET_VALS[7:0], or status_in[7:0] if RO).
- States:
  - IDLE: no transaction.
  - WAIT_PTR: START seen, no byte yet.
  - DATA: pointer loaded.
- Transitions:
  - Any state, txn_start_stb=1 -> WAIT_PTR; ptr unchanged, so a repeated-START read returns from the pointer set by the preceding write.
  - WAIT_PTR + rx_valid_stb -> ptr <= rx_data; go to DATA.
  - DATA + rx_valid_stb:
    - ptr < NUM_REGS and not RO: reg[ptr] <= rx_data; wr_stb[ptr]=1 next cycle.
    - ptr < NUM_REGS and RO: write silently dropped, no wr_stb.
    - ptr >= NUM_REGS: write dropped; err_stb=1.
    - In every case the pointer then advances.
  - tx_done_stb in WAIT_PTR or DATA: pointer advances; err_stb=1 if ptr was >= NUM_REGS.
  - tx_done_stb in IDLE: ignored.
- Pointer advance:
  - AUTO_INC=0: hold.
  - Else if ptr = NUM_REGS-1: WRAP=1 -> 0; WRAP=0 -> hold.
  - Else if ptr >= NUM_REGS: hold.
  - Else ptr+1.
- tx_data is registered.
  - Value = reg[ptr], or status_in slot if RO, or 8'hFF if ptr >= NUM_REGS.
  - Recomputed every cycle, so it reflects a new pointer or a new write 1 cycle later; the slave samples it no earlier than 2 cycles after tx_done_stb.
- Priority in the same cycle:
  - txn_start_stb beats rx_valid_stb and tx_done_stb; the coincident byte or strobe is discarded.
  - rx_valid_stb and tx_done_stb together: the write is processed and the pointer advances once.
- Read-only slots pass status_in combinationally to regs_q; registered when feeding tx_data.
- Reset mid-transaction: immediate return to the reset image; a partial transaction is abandoned with no wr_stb.

Test Plan:
- Reset, then read-only idle: assert/release rst -> regs_q = RESET_VALS, ptr_q=0, tx_data=RESET_VALS[7:0], wr_stb=0.
- Burst write: NUM_REGS=8; START, bytes 0x02,0xAA,0xBB -> reg2=0xAA, reg3=0xBB; wr_stb pulses 0x04 then 0x08; ptr_q=4.
- Repeated-START read: START,0x05; START; three tx_done_stb with reg5..7=0x11,0x22,0x33 -> tx_data sequence 0x11,0x22,0x33, then reg0 (WRAP=1).
- WRAP=0 and out-of-range: writes at ptr 7 saturate, last byte overwrites reg7; pointer byte 0x20 -> write drops, err_stb=1, tx_data=0xFF.
- RO and collisions:
  - RO_MASK=0x01, status_in[7:0]=0x5A; write 0x00,0x99 -> reg0 unchanged, no wr_stb, tx_data=0x5A.
  - START coincident with rx_valid_stb -> byte discarded, state WAIT_PTR.
